trace_buffer: RTL

- Parametrised, synthesisable instruction-commit trace capture for the RISC-V CPU, replacing free-running $fmonitor logging.
- Records per-commit pc, inst and register-writeback into a circular buffer, with pc-match trigger, post-trigger window and stop control.
- After freezing, drains oldest-first over a valid/ready port to a bench or debug host.
- Sits beside the CPU and taps its commit/writeback signals.

---
 rtl/trace_buffer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/trace_buffer.sv
// trace_buffer
//   Instruction-commit trace capture for the RISC-V CPU. Each committed
//   instruction (pc, inst, register writeback) is written into a circular
//   buffer. Capture can be frozen by an explicit stop pulse, or by a pc-match
//   trigger followed by a programmable post-trigger window. Once frozen, the
//   buffer drains oldest-first over a valid/ready read port, then returns to
//   IDLE.
//
//   Optional feature macro: TRACE_TIMESTAMP_EN
//     When defined, a free-running 32-bit cycle counter is kept. Arm clears
//     it. Every entry records the counter value at capture, and the rd_ts
//     output presents it alongside the other rd_* fields.
//
//   Ports
//     clk, reset           rising-edge clock, async active-high reset
//     arm, stop            pulse controls: restart capture / freeze capture
//     trig_en, trig_pc     pc-match trigger enable and compare value
//     post_len             entries captured after the trigger entry (0..DEPTH)
//     commit_*, wb_*       commit and writeback tap from the CPU
//     state                0 IDLE, 1 CAPTURE, 2 POST, 3 FROZEN
//     count                valid entries held
//     triggered, overflow  sticky status since the last arm
//     rd_valid, rd_ready   drain handshake, only active while FROZEN
//     rd_*                 fields of the oldest held entry
module trace_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              stop,
  input  logic              trig_en,
  input  logic [XLEN-1:0]   trig_pc,
  input  logic [ADDR_W:0]   post_len,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic [XLEN-1:0]   commit_inst,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              triggered,
  output logic              overflow,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [XLEN-1:0]   rd_pc,
  output logic [XLEN-1:0]   rd_inst,
  output logic [XLEN-1:0]   rd_wb_data,
  output logic              rd_wb_en,
  output logic [4:0]        rd_wb_addr
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]       rd_ts
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    FROZEN  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     post_cnt_q, post_cnt_d;
  logic                triggered_q, triggered_d;
  logic                overflow_q, overflow_d;
  logic                wr_en;
  logic [ADDR_W-1:0]   rd_idx;

  // Entry storage, one array per field. Not reset: only entries below
  // count are ever presented, so stale contents are never visible.
  logic [XLEN-1:0]     pc_mem    [DEPTH];
  logic [XLEN-1:0]     inst_mem  [DEPTH];
  logic [XLEN-1:0]     wbd_mem   [DEPTH];
  logic                wben_mem  [DEPTH];
  logic [4:0]          wba_mem   [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]         ts_q;
  logic [31:0]         ts_mem    [DEPTH];

  // Cycle counter. It wraps naturally at 2^32, and arm restarts it from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ts_q <= '0;
    else if (arm) ts_q <= '0;
    else          ts_q <= ts_q + 32'd1;
  end
`endif

  // State, pointer and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state logic. Arm overrides everything, including a commit or a
  // read handshake in the same cycle. A stop that coincides with a commit
  // still lets that commit land before freezing.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;

    if (arm) begin
      state_d     = CAPTURE;
      count_d     = '0;
      wr_ptr_d    = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        CAPTURE, POST: begin
          if (commit_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            // When full, the write lands on the oldest slot, so count
            // stays at DEPTH and the oldest entry moves up by one.
            if (count_q == DEPTH_C) overflow_d = 1'b1;
            else                    count_d    = count_q + ONE_C;
          end
          if (state_q == CAPTURE) begin
            if (trig_en && commit_valid && (commit_pc == trig_pc)) begin
              triggered_d = 1'b1;
              if (post_len == '0) begin
                state_d = FROZEN;
              end else begin
                state_d    = POST;
                post_cnt_d = post_len;
              end
            end
          end else if (commit_valid) begin
            post_cnt_d = post_cnt_q - ONE_C;
            if (post_cnt_q == ONE_C) state_d = FROZEN;
          end
          if (stop) state_d = FROZEN;
        end
        FROZEN: begin
          // An empty freeze (stop right after arm) falls back to IDLE.
          if (count_q == '0) begin
            state_d = IDLE;
          end else if (rd_ready) begin
            count_d = count_q - ONE_C;
            if (count_q == ONE_C) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Entry write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]   <= commit_pc;
      inst_mem[wr_ptr_q] <= commit_inst;
      wbd_mem[wr_ptr_q]  <= wb_data;
      wben_mem[wr_ptr_q] <= wb_en;
      wba_mem[wr_ptr_q]  <= wb_addr;
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[wr_ptr_q]   <= ts_q;
`endif
    end
  end

  // Oldest entry sits count slots behind the write pointer. A full count
  // of DEPTH truncates to zero, which correctly points at wr_ptr itself.
  assign rd_idx     = wr_ptr_q - count_q[ADDR_W-1:0];

  assign rd_valid   = (state_q == FROZEN) && (count_q != '0);
  assign rd_pc      = pc_mem[rd_idx];
  assign rd_inst    = inst_mem[rd_idx];
  assign rd_wb_data = wbd_mem[rd_idx];
  assign rd_wb_en   = wben_mem[rd_idx];
  assign rd_wb_addr = wba_mem[rd_idx];
`ifdef TRACE_TIMESTAMP_EN
  assign rd_ts      = ts_mem[rd_idx];
`endif

  assign state      = state_q;
  assign count      = count_q;
  assign triggered  = triggered_q;
  assign overflow   = overflow_q;

endmodule
